// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared encodings, defaults and helpers for elevator request capture
//
// Purpose: MOVE_DIR encodings, default sizing constants and the debounce
//          counter width helper used by elevator_requests and btn_debounce.
// Ports:   none (package).
package elevator_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } move_dir_e;

  localparam int DEF_BUTTONS_WIDTH   = 6;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  // Counter must be able to hold the saturation value DEBOUNCE_CYCLES itself.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - single-button synchroniser, debounce counter and press pulse
//
// Purpose: 2-FF synchroniser followed by a saturating counter that clears on
//          any low synchronised sample; press pulses once per press.
// Ports:   clk   - system clock
//          reset - synchronous active-low reset
//          raw   - asynchronous button input
//          press - one-cycle pulse, high during the cycle whose rising edge
//                  moves the counter from DEBOUNCE_CYCLES-1 to DEBOUNCE_CYCLES
module btn_debounce
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (!sync2) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Saturation at CNT_MAX means a held button never re-fires until released.
  assign press = sync2 && (cnt == CNT_MAX - 1'b1);

endmodule

// File: rtl/elevator_requests.sv
// rtl/elevator_requests.sv - debounced cab/hall request latching with floor summaries
//
// Purpose: debounces every cab and hall button, latches presses as pending
//          requests, clears them as floors are served and summarises pending
//          requests relative to the current floor. One instance per car.
// Optional: ELEV_REQ_CANCEL_EN - re-pressing a pending cab button cancels it.
// Ports:   CLK, RESET (sync active-low)
//          BTN_NUM_IN, BTN_UP_OUT, BTN_DOWN_OUT - raw cab / hall up / hall down
//          CURRENT_LEVEL (one-hot), DOOR_OPEN, MOVE_DIR, SERVICE - controller state
//          CAB_PENDING, UP_PENDING, DOWN_PENDING, ACTIVE_LEVELS - request vectors
//          REQ_ABOVE, REQ_BELOW, REQ_HERE, LEVEL_ERR - summaries
module elevator_requests
  import elevator_pkg::*;
#(
  parameter int BUTTONS_WIDTH   = DEF_BUTTONS_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [BUTTONS_WIDTH-1:0] BTN_NUM_IN,
  input  logic [BUTTONS_WIDTH-1:0] BTN_UP_OUT,
  input  logic [BUTTONS_WIDTH-1:0] BTN_DOWN_OUT,
  input  logic [BUTTONS_WIDTH-1:0] CURRENT_LEVEL,
  input  logic                     DOOR_OPEN,
  input  logic [1:0]               MOVE_DIR,
  input  logic                     SERVICE,
  output logic [BUTTONS_WIDTH-1:0] CAB_PENDING,
  output logic [BUTTONS_WIDTH-1:0] UP_PENDING,
  output logic [BUTTONS_WIDTH-1:0] DOWN_PENDING,
  output logic [BUTTONS_WIDTH-1:0] ACTIVE_LEVELS,
  output logic                     REQ_ABOVE,
  output logic                     REQ_BELOW,
  output logic                     REQ_HERE,
  output logic                     LEVEL_ERR
);

  localparam int W = BUTTONS_WIDTH;
  // No hall-up button on the top floor, no hall-down button on the ground floor.
  localparam logic [W-1:0] UP_MASK   = ~(W'(1) << (W - 1));
  localparam logic [W-1:0] DOWN_MASK = ~W'(1);

  logic [W-1:0] cab_press, up_press, down_press;
  logic [W-1:0] serve_clr, cab_clr, up_clr, down_clr;
  logic [W-1:0] cab_next, up_next, down_next;
  logic [W-1:0] below_mask, above_mask;
  logic         level_ok;

  for (genvar i = 0; i < W; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cab (
      .clk(CLK), .reset(RESET), .raw(BTN_NUM_IN[i]), .press(cab_press[i])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk(CLK), .reset(RESET), .raw(BTN_UP_OUT[i]), .press(up_press[i])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
      .clk(CLK), .reset(RESET), .raw(BTN_DOWN_OUT[i]), .press(down_press[i])
    );
  end

  assign level_ok = $onehot(CURRENT_LEVEL);

  always_comb begin
    serve_clr = '0;
    if (DOOR_OPEN && level_ok && !SERVICE) begin
      serve_clr = CURRENT_LEVEL;
    end
    // Reserved encoding 11 falls through both tests and behaves as idle.
    cab_clr  = serve_clr;
    up_clr   = (MOVE_DIR != DIR_DOWN) ? serve_clr : '0;
    down_clr = (MOVE_DIR != DIR_UP)   ? serve_clr : '0;

`ifdef ELEV_REQ_CANCEL_EN
    // Toggle: a press on a pending cab bit cancels it, otherwise sets it.
    cab_next  = (CAB_PENDING ^ cab_press) & ~cab_clr;
`else
    cab_next  = (CAB_PENDING | cab_press) & ~cab_clr;
`endif
    up_next   = (UP_PENDING | up_press) & ~up_clr & UP_MASK;
    down_next = (DOWN_PENDING | down_press) & ~down_clr & DOWN_MASK;

    if (SERVICE) begin
      cab_next  = '0;
      up_next   = '0;
      down_next = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      CAB_PENDING  <= '0;
      UP_PENDING   <= '0;
      DOWN_PENDING <= '0;
    end else begin
      CAB_PENDING  <= cab_next;
      UP_PENDING   <= up_next;
      DOWN_PENDING <= down_next;
    end
  end

  assign ACTIVE_LEVELS = CAB_PENDING | UP_PENDING | DOWN_PENDING;

  // For a one-hot level, subtracting one yields ones on every lower floor.
  assign below_mask = CURRENT_LEVEL - W'(1);
  assign above_mask = ~(below_mask | CURRENT_LEVEL);

  assign LEVEL_ERR = !level_ok;
  assign REQ_ABOVE = level_ok && |(ACTIVE_LEVELS & above_mask);
  assign REQ_BELOW = level_ok && |(ACTIVE_LEVELS & below_mask);
  assign REQ_HERE  = level_ok && |(ACTIVE_LEVELS & CURRENT_LEVEL);

endmodule
